elevator_motion_ctrl: RTL and testbench

Parametrised elevator motion controller and successor to the two-bit floor comparator. It queues floor requests in an internal FIFO and compares the head request with the current floor. It then drives the car floor by floor with a travel timer and runs a door-open dwell on arrival. It sits between the call-button decoder and the motor/door/display drivers.

---
 rtl/elevator_pkg.sv | 6 +
 rtl/elevator_req_fifo.sv | 47 ++++
 rtl/elevator_motion_ctrl.sv | 123 ++++++++++++
 tb/tb_elevator_motion_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared FSM state encoding and travel direction constants
package elevator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/elevator_req_fifo.sv
// elevator_req_fifo: synchronous request FIFO with combinational head and occupancy count
module elevator_req_fifo
  import elevator_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;
  assign full   = r_count == (AW+1)'(DEPTH);
  assign empty  = r_count == '0;
  assign count  = r_count;
  assign head   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  // storage array needs no reset; emptiness is tracked by the count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl: queues floor requests and moves the car floor by floor with door dwell
module elevator_motion_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 4,
  parameter int FLOOR_W       = $clog2(FLOORS),
  parameter int DEPTH         = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [FLOOR_W-1:0]     req_floor,
  output logic                   req_ready,
  output logic                   req_err,
  input  logic                   hold,
  output logic [FLOOR_W-1:0]     actual_floor,
  output logic [FLOOR_W-1:0]     target_floor,
  output logic                   down_up_flag,
  output logic                   stop_go_flag,
  output logic                   door_open,
  output logic [$clog2(DEPTH):0] pending
);
  localparam int TMAX = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  state_t             r_state;
  state_t             w_state_n;
  logic [FLOOR_W-1:0] r_floor;
  logic [FLOOR_W-1:0] w_floor_n;
  logic [TW-1:0]      r_timer;
  logic [TW-1:0]      w_timer_n;
  logic               r_dir;
  logic               w_dir_n;
  logic               r_err;
  logic               w_pop;
  logic               w_push;
  logic               w_bad;
  logic               w_full;
  logic               w_empty;
  logic [FLOOR_W-1:0] w_head;
  logic [FLOOR_W-1:0] w_step;
  assign w_bad  = 32'(req_floor) >= 32'(FLOORS);
  assign w_push = req_valid && !w_full && !w_bad;
  assign w_step = r_dir == DIR_UP ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
  elevator_req_fifo #(.WIDTH(FLOOR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (req_floor),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (pending)
  );
  assign req_ready    = !w_full;
  assign req_err      = r_err;
  assign actual_floor = r_floor;
  assign target_floor = w_empty ? '0 : w_head;
  assign stop_go_flag = r_state == MOVE;
  assign down_up_flag = r_state == MOVE && r_dir;
  assign door_open    = r_state == DOOR;
  // state, floor, timer and direction registers; error flag echoes a rejected out-of-range floor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_floor <= '0;
      r_timer <= '0;
      r_dir   <= DIR_DOWN;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_floor <= w_floor_n;
      r_timer <= w_timer_n;
      r_dir   <= w_dir_n;
      r_err   <= req_valid && !w_full && w_bad;
    end
  end
  // next-state logic; hold freezes everything, and the head is popped only on arrival
  always_comb begin
    w_state_n = r_state;
    w_floor_n = r_floor;
    w_timer_n = r_timer;
    w_dir_n   = r_dir;
    w_pop     = 1'b0;
    if (!hold) begin
      case (r_state)
        IDLE: begin
          if (!w_empty && w_head == r_floor) begin
            w_pop     = 1'b1;
            w_state_n = DOOR;
            w_timer_n = DOOR_LOAD;
          end else if (!w_empty) begin
            w_dir_n   = w_head > r_floor ? DIR_UP : DIR_DOWN;
            w_state_n = MOVE;
            w_timer_n = TRAVEL_LOAD;
          end
        end
        MOVE: begin
          if (r_timer == '0) begin
            w_floor_n = w_step;
            w_timer_n = TRAVEL_LOAD;
            if (w_step == w_head) begin
              w_pop     = 1'b1;
              w_state_n = DOOR;
              w_timer_n = DOOR_LOAD;
            end
          end else begin
            w_timer_n = r_timer - TW'(1);
          end
        end
        DOOR: begin
          w_state_n = r_timer == '0 ? IDLE : DOOR;
          w_timer_n = r_timer == '0 ? r_timer : r_timer - TW'(1);
        end
        default: w_state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb_elevator_motion_ctrl: directed self-checking bench for the elevator motion controller
module tb_elevator_motion_ctrl;
  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_floor;
  logic       req_ready;
  logic       req_err;
  logic       hold;
  logic [2:0] actual_floor;
  logic [2:0] target_floor;
  logic       down_up_flag;
  logic       stop_go_flag;
  logic       door_open;
  logic [2:0] pending;
  int checks = 0;
  int errors = 0;

  elevator_motion_ctrl #(
    .FLOORS(4), .FLOOR_W(3), .DEPTH(4), .TRAVEL_CYCLES(8), .DOOR_CYCLES(5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .req_ready    (req_ready),
    .req_err      (req_err),
    .hold         (hold),
    .actual_floor (actual_floor),
    .target_floor (target_floor),
    .down_up_flag (down_up_flag),
    .stop_go_flag (stop_go_flag),
    .door_open    (door_open),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] f);
    req_valid = 1'b1;
    req_floor = f;
    cyc(1);
    req_valid = 1'b0;
  endtask

  task automatic door_cycle();
    chk("door_open_arrive", door_open, 1);
    chk("stopped_arrive", stop_go_flag, 0);
    cyc(4);
    chk("door_open_last", door_open, 1);
    cyc(1);
    chk("door_closed", door_open, 0);
    chk("idle_pending", pending, 0);
  endtask

  task automatic trip(input int from, input int to);
    int s;
    s = to > from ? 1 : -1;
    push(3'(to));
    chk("pending_after_push", pending, 1);
    chk("target_after_push", target_floor, 32'(to));
    chk("not_moving_yet", stop_go_flag, 0);
    cyc(1);
    if (to == from) begin
      door_cycle();
    end else begin
      chk("moving", stop_go_flag, 1);
      chk("direction", down_up_flag, to > from ? 1 : 0);
      for (int k = 1; k <= (to > from ? to - from : from - to); k++) begin
        cyc(7);
        chk("floor_before_step", actual_floor, 32'(from + (k - 1) * s));
        cyc(1);
        chk("floor_after_step", actual_floor, 32'(from + k * s));
      end
      door_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_floor = '0;
    hold = 1'b0;
    #1;
    chk("rst_floor", actual_floor, 0);
    chk("rst_target", target_floor, 0);
    chk("rst_go", stop_go_flag, 0);
    chk("rst_door", door_open, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_err", req_err, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_empty", stop_go_flag, 0);
    trip(0, 3);
    trip(3, 0);
    trip(0, 2);
    trip(2, 2);
    trip(2, 0);
    req_valid = 1'b1;
    req_floor = 3'd1;
    cyc(1);
    req_floor = 3'd3;
    cyc(1);
    req_floor = 3'd0;
    cyc(1);
    req_floor = 3'd2;
    cyc(1);
    chk("fifo_full_pending", pending, 4);
    chk("fifo_full_ready", req_ready, 0);
    req_floor = 3'd1;
    cyc(1);
    req_valid = 1'b0;
    chk("fifth_ignored", pending, 4);
    chk("full_no_err", req_err, 0);
    cyc(5);
    chk("q1_floor", actual_floor, 1);
    chk("q1_door", door_open, 1);
    chk("q1_pending", pending, 3);
    chk("q1_target", target_floor, 3);
    cyc(22);
    chk("q2_floor", actual_floor, 3);
    chk("q2_door", door_open, 1);
    chk("q2_target", target_floor, 0);
    cyc(30);
    chk("q3_floor", actual_floor, 0);
    chk("q3_door", door_open, 1);
    chk("q3_target", target_floor, 2);
    cyc(22);
    chk("q4_floor", actual_floor, 2);
    chk("q4_door", door_open, 1);
    chk("q4_pending", pending, 0);
    cyc(5);
    chk("q4_closed", door_open, 0);
    chk("err_before", req_err, 0);
    push(3'd4);
    chk("err_floor4", req_err, 1);
    chk("err4_not_queued", pending, 0);
    push(3'd5);
    chk("err_floor5", req_err, 1);
    chk("err5_not_queued", pending, 0);
    cyc(1);
    chk("err_one_pulse", req_err, 0);
    chk("err_no_motion", stop_go_flag, 0);
    push(3'd0);
    cyc(3);
    hold = 1'b1;
    chk("hold_go", stop_go_flag, 1);
    chk("hold_dir", down_up_flag, 0);
    cyc(5);
    chk("hold_floor_frozen", actual_floor, 2);
    chk("hold_go_kept", stop_go_flag, 1);
    cyc(5);
    hold = 1'b0;
    cyc(5);
    chk("hold_move_late", actual_floor, 2);
    cyc(1);
    chk("hold_move_step", actual_floor, 1);
    cyc(8);
    chk("hold_arrive", actual_floor, 0);
    chk("hold_arrive_door", door_open, 1);
    cyc(1);
    hold = 1'b1;
    push(3'd3);
    chk("hold_push_pending", pending, 1);
    chk("hold_door_kept", door_open, 1);
    cyc(8);
    hold = 1'b0;
    cyc(3);
    chk("hold_door_extended", door_open, 1);
    cyc(1);
    chk("hold_door_closed", door_open, 0);
    cyc(1);
    chk("resume_go", stop_go_flag, 1);
    chk("resume_dir", down_up_flag, 1);
    cyc(10);
    chk("mid_move_floor", actual_floor, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_floor", actual_floor, 0);
    chk("amid_go", stop_go_flag, 0);
    chk("amid_dir", down_up_flag, 0);
    chk("amid_door", door_open, 0);
    chk("amid_pending", pending, 0);
    chk("amid_target", target_floor, 0);
    chk("amid_ready", req_ready, 1);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_idle", stop_go_flag, 0);
    chk("post_rst_floor", actual_floor, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
